// File: rtl/wb_sdram_bridge.sv
`timescale 1ns/1ps
// Wishbone slave front-end for sdram_controller: address-window decode, posted-write
// FIFO with byte masks, reads ordered behind posted writes, read timeout as bus error.
module wb_sdram_bridge #(
   parameter logic [31:0] ADDR_BASE   = 32'h3800_0000,
   parameter int          WIN_BITS    = 23,
   parameter int          WFIFO_DEPTH = 4,
   parameter int          TIMEOUT     = 1023
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_dat_i,
   input  logic [31:0]         wbs_adr_i,
   output logic                wbs_ack_o,
   output logic                wbs_err_o,
   output logic [31:0]         wbs_dat_o,
   output logic                ctrl_in_valid,
   output logic                ctrl_rw,
   output logic [WIN_BITS-3:0] ctrl_addr,
   output logic [31:0]         ctrl_wdata,
   output logic [3:0]          ctrl_wmask,
   input  logic                ctrl_busy,
   input  logic [31:0]         ctrl_rdata,
   input  logic                ctrl_out_valid,
   output logic                idle_o
);
   localparam int AW = WIN_BITS - 2;
   localparam int PW = $clog2(WFIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RD_DRAIN, RD_ISSUE, RD_WAIT} state_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic [3:0]    mask;
   } wentry_t;

   state_t        state, state_d;
   wentry_t       fifo [WFIFO_DEPTH];
   wentry_t       head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [TW-1:0] timer;
   logic [AW-1:0] rd_addr;
   logic [31:0]   dat_q;
   logic          ack_q, err_q;
   logic          req, hit, in_idle, empty, full, push, pop, drain, rd_issue;
   logic          rd_start, rd_done, timed_out;
   logic          unused_adr;

   assign unused_adr = ^wbs_adr_i[1:0];

   always_comb begin
      req       = wbs_stb_i & wbs_cyc_i & ~ack_q & ~err_q;
      hit       = (wbs_adr_i[31:WIN_BITS] == ADDR_BASE[31:WIN_BITS]);
      in_idle   = (state == IDLE);
      empty     = (count == '0);
      full      = (count == CW'(WFIFO_DEPTH));
      // New requests are only taken in IDLE; the read in flight keeps stb high meanwhile.
      push      = in_idle & req & hit & wbs_we_i & ~full;
      rd_start  = in_idle & req & hit & ~wbs_we_i;
      // Gated by reset so nothing is offered to the controller during a reset cycle.
      drain     = ~empty & (state != RD_ISSUE) & (state != RD_WAIT) & ~wb_rst_i;
      rd_issue  = (state == RD_ISSUE) & ~wb_rst_i;
      pop       = drain & ~ctrl_busy;
      rd_done   = (state == RD_WAIT) & ctrl_out_valid;
      // Error registers on the same edge at which the wait count reaches TIMEOUT.
      timed_out = (state == RD_WAIT) & ~ctrl_out_valid & (timer == TW'(TIMEOUT - 1));
      head      = fifo[rd_ptr];
   end

   always_comb begin
      ctrl_in_valid = drain | rd_issue;
      ctrl_rw       = drain;
      ctrl_addr     = '0;
      ctrl_wdata    = '0;
      ctrl_wmask    = '0;
      if (drain) begin
         ctrl_addr  = head.addr;
         ctrl_wdata = head.data;
         ctrl_wmask = head.mask;
      end else if (rd_issue) begin
         ctrl_addr  = rd_addr;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_err_o = err_q;
   assign wbs_dat_o = dat_q;
   assign idle_o    = empty & in_idle;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:     if (rd_start)              state_d = RD_DRAIN;
         RD_DRAIN: if (empty)                 state_d = RD_ISSUE;
         RD_ISSUE: if (!ctrl_busy)            state_d = RD_WAIT;
         RD_WAIT:  if (rd_done || timed_out)  state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) fifo[wr_ptr] <= '{addr: wbs_adr_i[WIN_BITS-1:2], data: wbs_dat_i, mask: ~wbs_sel_i};
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         timer   <= '0;
         rd_addr <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         // A response seen after cyc dropped completes the read silently.
         ack_q <= push | (rd_done & wbs_cyc_i);
         err_q <= (in_idle & req & ~hit) | (timed_out & wbs_cyc_i);
         if (rd_done)        dat_q <= ctrl_rdata;
         else if (timed_out) dat_q <= 32'hDEAD_BEEF;
         if (rd_start) rd_addr <= wbs_adr_i[WIN_BITS-1:2];
         if (state == RD_ISSUE)     timer <= '0;
         else if (state == RD_WAIT) timer <= timer + TW'(1);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_wb_sdram_bridge.sv
`timescale 1ns/1ps
// Bench for wb_sdram_bridge: vector table, hand-written corner sequences, and random
// traffic checked against a word-level memory model behind a randomly busy controller.
module tb_wb_sdram_bridge;
   localparam int TMO = 40;

   logic        clk = 1'b0;
   logic        wb_rst_i, wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i, wbs_adr_i;
   logic        wbs_ack_o, wbs_err_o;
   logic [31:0] wbs_dat_o;
   logic        ctrl_in_valid, ctrl_rw;
   logic [20:0] ctrl_addr;
   logic [31:0] ctrl_wdata;
   logic [3:0]  ctrl_wmask;
   logic        ctrl_busy, ctrl_out_valid;
   logic [31:0] ctrl_rdata;
   logic        idle_o;

   // controller model state
   logic        model_busy = 1'b0, model_ov = 1'b0, force_busy = 1'b0, ov_inject = 1'b0;
   logic [31:0] model_rdata = '0, inj_data = '0, pend_data, sd_w;
   logic        rand_mode = 1'b0, resp_en = 1'b1;
   int          pend = 0, cyc_n = 0, acc_cyc = 0;
   logic [31:0] sd_mem [int];

   typedef struct {
      logic        rw;
      logic [20:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } clog_t;
   clog_t log_q [$];

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        exp_err;
      logic [20:0] exp_caddr;
      logic [3:0]  exp_mask;
      logic [31:0] exp_rdata;
   } vec_t;

   int n_pass = 0, n_total = 0;

   assign ctrl_busy      = model_busy | force_busy;
   assign ctrl_out_valid = model_ov | ov_inject;
   assign ctrl_rdata     = ov_inject ? inj_data : model_rdata;

   wb_sdram_bridge #(.TIMEOUT(TMO)) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
      .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
      .ctrl_in_valid(ctrl_in_valid), .ctrl_rw(ctrl_rw), .ctrl_addr(ctrl_addr),
      .ctrl_wdata(ctrl_wdata), .ctrl_wmask(ctrl_wmask), .ctrl_busy(ctrl_busy),
      .ctrl_rdata(ctrl_rdata), .ctrl_out_valid(ctrl_out_valid), .idle_o(idle_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_init(input int a);
      return 32'h5A5A_0000 ^ 32'(a);
   endfunction

   // SDRAM controller model: random busy, read data returned 1..4 cycles after acceptance.
   always begin
      @(posedge clk); #1;
      cyc_n++;
      model_ov   = 1'b0;
      model_busy = rand_mode && ($urandom_range(0, 2) == 0);
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            model_ov    = 1'b1;
            model_rdata = pend_data;
         end
      end
      @(negedge clk);
      if (wb_rst_i) pend = 0;
      else if (ctrl_in_valid && !ctrl_busy) begin
         log_q.push_back('{ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_wmask});
         acc_cyc = cyc_n;
         sd_w = sd_mem.exists(int'(ctrl_addr)) ? sd_mem[int'(ctrl_addr)] : mem_init(int'(ctrl_addr));
         if (ctrl_rw) begin
            for (int b = 0; b < 4; b++)
               if (!ctrl_wmask[b]) sd_w[b*8 +: 8] = ctrl_wdata[b*8 +: 8];
            sd_mem[int'(ctrl_addr)] = sd_w;
         end else if (resp_en) begin
            pend      = rand_mode ? int'($urandom_range(1, 4)) : 2;
            pend_data = sd_w;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_total=%0d", n_total);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %h required %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wb_start(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
   endtask

   // Waits up to max cycles for ack/err; lat = cycles after the request cycle. Ends at posedge+1.
   task automatic wb_wait(input int max, output logic ga, output logic ge, output int lat,
                          output logic [31:0] d, output int at);
      int k;
      ga = 1'b0; ge = 1'b0; d = '0; at = 0; k = 0;
      while (k <= max && !ga && !ge) begin
         @(negedge clk);
         k++;
         ga = wbs_ack_o; ge = wbs_err_o; d = wbs_dat_o; at = cyc_n;
      end
      lat = k - 1;
      tick();
      if (ga || ge) begin
         wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name, input int max);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!idle_o && k < max);
      check(name, idle_o, 1'b1);
      tick();
   endtask

   initial begin
      vec_t        vecs [10];
      logic        ga, ge;
      int          lat, at, base;
      logic [31:0] d;
      logic [31:0] ref_mem [int];

      vecs[0] = '{1'b1, 32'h3800_0010, 4'hF,    32'h0BAD_F00D, 1'b0, 21'h4,      4'h0,    32'h0};
      vecs[1] = '{1'b0, 32'h3800_0010, 4'hF,    32'h0,         1'b0, 21'h4,      4'h0,    32'h0BAD_F00D};
      vecs[2] = '{1'b1, 32'h3800_0020, 4'b0011, 32'h1122_3344, 1'b0, 21'h8,      4'b1100, 32'h0};
      vecs[3] = '{1'b0, 32'h3800_0020, 4'hF,    32'h0,         1'b0, 21'h8,      4'h0,    32'h5A5A_3344};
      vecs[4] = '{1'b1, 32'h3000_0000, 4'hF,    32'hFFFF_FFFF, 1'b1, 21'h0,      4'h0,    32'h0};
      vecs[5] = '{1'b0, 32'h3000_0004, 4'hF,    32'h0,         1'b1, 21'h0,      4'h0,    32'h0};
      vecs[6] = '{1'b1, 32'h387F_FFFC, 4'b1000, 32'hDDCC_BBAA, 1'b0, 21'h1F_FFFF, 4'b0111, 32'h0};
      vecs[7] = '{1'b0, 32'h387F_FFFC, 4'hF,    32'h0,         1'b0, 21'h1F_FFFF, 4'h0,    32'hDD45_FFFF};
      vecs[8] = '{1'b0, 32'h3880_0000, 4'hF,    32'h0,         1'b1, 21'h0,      4'h0,    32'h0};
      vecs[9] = '{1'b1, 32'h37FF_FFFC, 4'hF,    32'h1234_5678, 1'b1, 21'h0,      4'h0,    32'h0};

      wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = '0; wbs_dat_i = '0; wbs_adr_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ack", wbs_ack_o, 1'b0);
      check("rst_err", wbs_err_o, 1'b0);
      check("rst_dat", wbs_dat_o, 32'h0);
      check("rst_civ", ctrl_in_valid, 1'b0);
      check("rst_rw", ctrl_rw, 1'b0);
      check("rst_addr", ctrl_addr, 21'h0);
      check("rst_wdata", ctrl_wdata, 32'h0);
      check("rst_wmask", ctrl_wmask, 4'h0);
      check("rst_idle", idle_o, 1'b1);
      tick();
      wb_rst_i = 1'b0;
      tick();

      // single transactions from the vector table
      for (int i = 0; i < 10; i++) begin
         base = log_q.size();
         wb_start(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat);
         wb_wait(60, ga, ge, lat, d, at);
         check($sformatf("vec%0d_resp", i), {ga, ge}, vecs[i].exp_err ? 2'b01 : 2'b10);
         if (vecs[i].we || vecs[i].exp_err) check($sformatf("vec%0d_lat", i), lat, 1);
         if (!vecs[i].we && !vecs[i].exp_err) check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
         wait_idle($sformatf("vec%0d_idle", i), 60);
         check($sformatf("vec%0d_nctrl", i), log_q.size() - base, vecs[i].exp_err ? 0 : 1);
         if (!vecs[i].exp_err && log_q.size() > base) begin
            check($sformatf("vec%0d_caddr", i), log_q[base].addr, vecs[i].exp_caddr);
            check($sformatf("vec%0d_crw", i), log_q[base].rw, vecs[i].we);
            check($sformatf("vec%0d_cmask", i), log_q[base].mask, vecs[i].exp_mask);
         end
      end

      // posted writes fill the FIFO while the controller is busy; the fifth stalls
      force_busy = 1'b1;
      base = log_q.size();
      for (int k = 0; k < 4; k++) begin
         wb_start(1'b1, 32'h3800_0000 + 32'(4 * k), 4'hF, 32'h1000 + 32'(k));
         wb_wait(10, ga, ge, lat, d, at);
         check($sformatf("post%0d_ack", k), {ga, ge}, 2'b10);
         check($sformatf("post%0d_lat", k), lat, 1);
      end
      @(negedge clk);
      check("post_hold", {ctrl_in_valid, ctrl_rw, ctrl_addr}, {2'b11, 21'h0});
      tick();
      wb_start(1'b1, 32'h3800_0010, 4'hF, 32'h1004);
      wb_wait(8, ga, ge, lat, d, at);
      check("post_stall", {ga, ge}, 2'b00);
      force_busy = 1'b0;
      wb_wait(10, ga, ge, lat, d, at);
      check("post_stall_ack", {ga, ge}, 2'b10);
      wait_idle("post_idle", 40);
      check("post_nctrl", log_q.size() - base, 5);
      if (log_q.size() >= base + 5)
         for (int k = 0; k < 5; k++) begin
            check($sformatf("post_order%0d", k), log_q[base + k].addr, 21'(k));
            check($sformatf("post_data%0d", k), log_q[base + k].wdata, 32'h1000 + 32'(k));
         end

      // read immediately behind a posted write
      force_busy = 1'b1;
      base = log_q.size();
      wb_start(1'b1, 32'h3800_0010, 4'hF, 32'hA5A5_1234);
      wb_wait(10, ga, ge, lat, d, at);
      check("raw_wr_ack", {ga, ge}, 2'b10);
      wb_start(1'b0, 32'h3800_0010, 4'hF, 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("raw_hold%0d", k), {ctrl_in_valid, ctrl_rw}, 2'b11);
      end
      tick();
      force_busy = 1'b0;
      wb_wait(40, ga, ge, lat, d, at);
      check("raw_rd_ack", {ga, ge}, 2'b10);
      check("raw_rdata", d, 32'hA5A5_1234);
      check("raw_nctrl", log_q.size() - base, 2);
      if (log_q.size() >= base + 2) begin
         check("raw_first", {log_q[base].rw, log_q[base].addr}, {1'b1, 21'h4});
         check("raw_second", {log_q[base + 1].rw, log_q[base + 1].addr}, {1'b0, 21'h4});
      end
      wait_idle("raw_idle", 20);

      // read timeout: controller never answers
      resp_en = 1'b0;
      wb_start(1'b0, 32'h3800_0004, 4'hF, 32'h0);
      wb_wait(TMO + 30, ga, ge, lat, d, at);
      check("tmo_resp", {ga, ge}, 2'b01);
      check("tmo_dat", d, 32'hDEAD_BEEF);
      check("tmo_cycles", at - (acc_cyc + 1), TMO);
      tick();
      inj_data = 32'h1234_5678; ov_inject = 1'b1;
      tick();
      ov_inject = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("tmo_late%0d", k), {wbs_ack_o, wbs_err_o}, 2'b00);
      end
      check("tmo_dat_hold", wbs_dat_o, 32'hDEAD_BEEF);
      check("tmo_idle", idle_o, 1'b1);
      tick();
      resp_en = 1'b1;

      // reset with three writes still queued
      force_busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wb_start(1'b1, 32'h3800_0040 + 32'(4 * k), 4'hF, 32'hC0DE_0000 + 32'(k));
         wb_wait(10, ga, ge, lat, d, at);
         check($sformatf("rstq%0d_ack", k), {ga, ge}, 2'b10);
      end
      @(negedge clk);
      check("rstq_pending", {ctrl_in_valid, idle_o}, 2'b10);
      tick();
      wb_rst_i = 1'b1;
      tick();
      wb_rst_i = 1'b0;
      @(negedge clk);
      check("rstq_civ", ctrl_in_valid, 1'b0);
      check("rstq_idle", idle_o, 1'b1);
      check("rstq_resp", {wbs_ack_o, wbs_err_o}, 2'b00);
      tick();
      force_busy = 1'b0;
      base = log_q.size();
      repeat (10) @(negedge clk);
      check("rstq_no_writes", log_q.size() - base, 0);
      tick();

      // random traffic against a word-level reference memory
      rand_mode = 1'b1;
      for (int t = 0; t < 200; t++) begin
         logic        rwe, miss;
         int          word;
         logic [31:0] adr, dat, expd;
         logic [3:0]  sel;
         rwe  = 1'($urandom_range(0, 1));
         miss = ($urandom_range(0, 9) == 0);
         word = 64 + int'($urandom_range(0, 15));
         adr  = (miss ? 32'h4000_0000 : 32'h3800_0000) + 32'(4 * word);
         sel  = 4'($urandom);
         dat  = $urandom;
         wb_start(rwe, adr, sel, dat);
         wb_wait(300, ga, ge, lat, d, at);
         check($sformatf("rnd%0d_resp", t), {ga, ge}, miss ? 2'b01 : 2'b10);
         if (!miss) begin
            expd = ref_mem.exists(word) ? ref_mem[word] : mem_init(word);
            if (rwe) begin
               for (int b = 0; b < 4; b++)
                  if (sel[b]) expd[b*8 +: 8] = dat[b*8 +: 8];
               ref_mem[word] = expd;
            end else begin
               check($sformatf("rnd%0d_rdata", t), d, expd);
            end
         end
         repeat ($urandom_range(0, 2)) tick();
      end
      wait_idle("rnd_idle", 100);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
